// File: rtl/fp32_pkg.sv
// Shared constants and the S1->S2 payload type for the FP32 multiplier back end.
package fp32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_FRAC_W  = 23;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP32_NEG_INF  = 32'hFF80_0000;

    // Payload field widths for the default multiplier geometry (8-bit exponents, 24x18 mantissas).
    localparam int MUL_EXP_W  = 9;
    localparam int MUL_PROD_W = 42;
    localparam int MUL_POS_W  = 6;

    typedef struct packed {
        logic                        sign;
        logic                        zero;
        logic [MUL_POS_W-1:0]        pos;
        logic [MUL_PROD_W-1:0]       mag;
        logic signed [MUL_EXP_W-1:0] exp;
    } s1_payload_t;

endpackage

// File: rtl/fp32_lzc.sv
// Leading-one detector: position of the most significant set bit, plus an all-zero flag.
module fp32_lzc #(
    parameter int W = 42
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] pos,
    output logic                 zero
);

    always_comb begin
        // NOTE: default assigned first so every path drives pos and no latch is inferred.
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) pos = ($clog2(W))'(i);
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/fp32_multiplier_normalize_pack_stage.sv
// Normalize/round/pack back end of the FP32 multiplier: 2-stage valid/ready pipeline.
// Define FP32_MUL_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module fp32_multiplier_normalize_pack_stage
    import fp32_pkg::*;
#(
    parameter int EXPONENT_WIDTH    = 8,
    parameter int MANTISSA_A_WIDTH  = 24,
    parameter int MANTISSA_B_WIDTH  = 18,
    parameter int PRODUCT_FRAC_BITS = 39
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic signed [EXPONENT_WIDTH:0]             exponent_in,
    input  logic [MANTISSA_A_WIDTH+MANTISSA_B_WIDTH-1:0] mantissa_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [31:0]                                out_data
);

    localparam int PW       = MANTISSA_A_WIDTH + MANTISSA_B_WIDTH;
    localparam int POS_W    = $clog2(PW);
    localparam int EXP_IN_W = EXPONENT_WIDTH + 1;
    localparam int EB_W     = EXPONENT_WIDTH + 4;
    localparam int SIG_W    = FP32_FRAC_W + 1;
    localparam int LOW_W    = PW - SIG_W;

    localparam logic signed [EB_W-1:0] EXP_OVF = EB_W'(FP32_EXP_MAX);

    logic             s1_valid;
    logic             s1_advance;
    s1_payload_t      s1_d;
    s1_payload_t      s1_q;
    logic [PW-1:0]    in_mag;
    logic [POS_W-1:0] in_pos;
    logic             in_zero;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // Magnitude is PW bits unsigned so the most-negative product still fits.
    assign in_mag = mantissa_in[PW-1] ? (~mantissa_in) + PW'(1) : mantissa_in;

    fp32_lzc #(.W(PW)) u_lzc (
        .value (in_mag),
        .pos   (in_pos),
        .zero  (in_zero)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.sign = mantissa_in[PW-1];
        s1_d.zero = in_zero;
        s1_d.pos  = in_pos;
        s1_d.mag  = in_mag;
        s1_d.exp  = exponent_in;
    end

    // S2: normalize so the leading one sits at the hidden-bit position.
    logic [POS_W-1:0]       shamt;
    logic [FP32_FRAC_W-1:0] frac_pre;
    logic [FP32_FRAC_W-1:0] frac_r;
    logic                   carry;
    logic signed [EB_W-1:0] e_b;
    logic signed [EB_W-1:0] e_r;
    logic [31:0]            pack_word;

    always_comb begin
        shamt    = POS_W'(PW - 1) - s1_q.pos;
        frac_pre = FP32_FRAC_W'((s1_q.mag << shamt) >> LOW_W);
        e_b      = {{(EB_W-EXP_IN_W){s1_q.exp[EXP_IN_W-1]}}, s1_q.exp}
                 + {{(EB_W-POS_W){1'b0}}, s1_q.pos}
                 - EB_W'(PRODUCT_FRAC_BITS)
                 + EB_W'(FP32_BIAS);
    end

`ifdef FP32_MUL_ROUND_EN
    logic [LOW_W-1:0] low_bits;
    logic             guard;
    logic             sticky;
    logic             round_up;

    always_comb begin
        low_bits = LOW_W'(s1_q.mag << shamt);
        guard    = low_bits[LOW_W-1];
        sticky   = |low_bits[LOW_W-2:0];
        round_up = guard && (sticky || frac_pre[0]);
        // Carry-out means the significand reached 2.0: frac wraps to zero and the exponent bumps.
        {carry, frac_r} = {1'b0, frac_pre} + SIG_W'(round_up);
    end
`else
    assign carry  = 1'b0;
    assign frac_r = frac_pre;
`endif

    always_comb begin
        e_r = e_b + {{(EB_W-1){1'b0}}, carry};
        if (s1_q.zero) begin
            pack_word = FP32_POS_ZERO;
        end else if (e_r >= EXP_OVF) begin
            pack_word = s1_q.sign ? FP32_NEG_INF : FP32_POS_INF;
        end else if (e_r[EB_W-1] || e_r == '0) begin
            pack_word = {s1_q.sign, 31'h0};
        end else begin
            pack_word = {s1_q.sign, e_r[7:0], frac_r};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP32_POS_ZERO;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            if (in_ready) s1_valid <= in_valid;
            if (s1_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= pack_word;
            end
        end
    end

    // NOTE: the payload register has no reset; s1_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) s1_q <= s1_d;
    end

endmodule

// File: tb/tb_fp32_multiplier_normalize_pack_stage.sv
// Directed bench for fp32_multiplier_normalize_pack_stage; expectations follow FP32_MUL_ROUND_EN.
`timescale 1ns/1ps
module tb_fp32_multiplier_normalize_pack_stage;

`ifdef FP32_MUL_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [8:0] exponent_in = '0;
    logic [41:0]       mantissa_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fp32_multiplier_normalize_pack_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .exponent_in (exponent_in),
        .mantissa_in (mantissa_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    typedef struct {
        logic signed [8:0] e;
        logic [41:0]       m;
        logic [31:0]       exp_rne;
        logic [31:0]       exp_trunc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic vec_t mk(input int e, input longint m, input logic [31:0] r, input logic [31:0] t);
        vec_t v;
        v.e         = 9'(e);
        v.m         = 42'(m);
        v.exp_rne   = r;
        v.exp_trunc = t;
        return v;
    endfunction

    localparam longint ONE39 = 64'sd1 << 39;
    localparam longint ALL1S = (64'sd16777215 << 16) | (64'sd1 << 15);

    initial begin
        int idx;
        int got;
        int cyc;
        int n;
        int stale;
        logic [31:0] snap;
        bit have_snap;
        logic [31:0] bp_exp [4];

        vecs.push_back(mk(0,    ONE39,                          32'h3F80_0000, 32'h3F80_0000));
        vecs.push_back(mk(1,    -(64'sd3 << 38),                32'hC040_0000, 32'hC040_0000));
        vecs.push_back(mk(77,   0,                              32'h0000_0000, 32'h0000_0000));
        vecs.push_back(mk(200,  ONE39,                          32'h7F80_0000, 32'h7F80_0000));
        vecs.push_back(mk(-130, ONE39,                          32'h0000_0000, 32'h0000_0000));
        vecs.push_back(mk(200,  -ONE39,                         32'hFF80_0000, 32'hFF80_0000));
        vecs.push_back(mk(0,    ONE39 + (64'sd3 << 15),         32'h3F80_0002, 32'h3F80_0001));
        vecs.push_back(mk(127,  ONE39,                          32'h7F00_0000, 32'h7F00_0000));
        vecs.push_back(mk(128,  ONE39,                          32'h7F80_0000, 32'h7F80_0000));
        vecs.push_back(mk(-126, ONE39,                          32'h0080_0000, 32'h0080_0000));
        vecs.push_back(mk(-127, ONE39,                          32'h0000_0000, 32'h0000_0000));
        vecs.push_back(mk(-127, -ONE39,                         32'h8000_0000, 32'h8000_0000));
        vecs.push_back(mk(0,    -(64'sd1 << 41),                32'hC080_0000, 32'hC080_0000));
        vecs.push_back(mk(39,   1,                              32'h3F80_0000, 32'h3F80_0000));
        vecs.push_back(mk(0,    ALL1S,                          32'h4000_0000, 32'h3FFF_FFFF));
        vecs.push_back(mk(127,  ALL1S,                          32'h7F80_0000, 32'h7F7F_FFFF));
        vecs.push_back(mk(0,    ONE39 + (64'sd1 << 15),         32'h3F80_0000, 32'h3F80_0000));
        vecs.push_back(mk(0,    ONE39 + (64'sd1 << 15) + 1,     32'h3F80_0001, 32'h3F80_0000));
        vecs.push_back(mk(-3,   -(64'sd5 << 37),                32'hBE20_0000, 32'hBE20_0000));
        vecs.push_back(mk(255,  1,                              32'h7F80_0000, 32'h7F80_0000));

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Two-cycle latency and single emission
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        exponent_in = 9'sd0;
        mantissa_in = 42'(ONE39);
        #1 check("lat_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_data", out_data, 32'h3F80_0000);
        @(negedge clk); #1;
        check("lat_no_dup", 32'(out_valid), 32'd0);

        // Table vectors streamed back to back
        @(negedge clk);
        n = vecs.size();
        idx = 0; got = 0; cyc = 0;
        out_ready = 1'b1;
        while (got < n && cyc < n + 20) begin
            in_valid = (idx < n);
            if (idx < n) begin
                exponent_in = vecs[idx].e;
                mantissa_in = vecs[idx].m;
            end
            #1;
            if (out_valid) begin
                check($sformatf("vec%0d", got), out_data,
                      ROUND_EN ? vecs[got].exp_rne : vecs[got].exp_trunc);
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(got), 32'(n));
        check("stream_cycles", 32'(cyc), 32'(n + 2));

        // Back-pressure: out_ready low for the first 5 cycles
        bp_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000};
        @(negedge clk);
        idx = 0; got = 0; have_snap = 1'b0; snap = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            out_ready = (c >= 5);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                exponent_in = 9'(idx);
                mantissa_in = 42'(ONE39);
            end
            #1;
            if (out_valid && !out_ready) begin
                if (have_snap) check("bp_hold", out_data, snap);
                else begin
                    snap      = out_data;
                    have_snap = 1'b1;
                end
            end
            if (c == 4) begin
                check("bp_accepts", 32'(idx), 32'd2);
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_out%0d", got), out_data, bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got), 32'd4);
        @(negedge clk); #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset with both stages full
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        exponent_in = 9'sd5;
        mantissa_in = 42'(ONE39);
        @(negedge clk);
        exponent_in = 9'sd6;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_full_out_valid", 32'(out_valid), 32'd1);
        check("rst_full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_data", out_data, 32'h0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (out_valid) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);

        // Pipeline recovers after reset
        @(negedge clk);
        in_valid    = 1'b1;
        exponent_in = 9'sd1;
        mantissa_in = 42'(-(64'sd3 << 38));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", out_data, 32'hC040_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
